// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: transmitter state encoding, microsecond-to-cycle
// conversion and odd parity. Imported by ps2_host_tx and keyboard_controller.
// No ports; compile before any module that imports it.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_BITS,
        ST_ACK,
        ST_WAIT_REL,
        ST_FAIL
    } ps2_tx_state_t;

    // Clock cycles in 'us' microseconds at 'hz'; 64-bit product avoids
    // overflow at 50 MHz x 15 ms.
    function automatic int cycles_from_us(input longint hz, input longint us);
        return int'((hz * us) / 64'd1_000_000);
    endfunction

    // PS/2 frames carry odd parity: the parity bit makes the count of ones
    // across data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Purpose: 2-FF synchroniser plus FILT_LEN-sample glitch filter and fall detect for one PS/2 line.
// Latency: 2 + FILT_LEN cycles from pin change to level/fall update.
// Backpressure: none; free-running, one sample per clock.
// Ports: clk, rst (sync, active-high); line = async pin level;
//        level = filtered level (resets to 1, idle line); fall = 1-cycle pulse on filtered 1->0.
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic fall
);

    localparam int RUN_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(FILT_LEN - 1);

    logic [1:0]       sync;
    logic [RUN_W-1:0] run;   // consecutive synchronised samples that differ from level

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            level <= 1'b1;
            run   <= '0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line};
            fall <= 1'b0;
            if (sync[1] == level) begin
                run <= '0;
            end else if (run == RUN_LAST) begin
                // FILT_LEN-th consecutive differing sample: accept new level.
                level <= sync[1];
                run   <= '0;
                fall  <= level;   // old level 1 -> new level 0
            end else begin
                run <= run + RUN_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Purpose: host-to-device PS/2 command transmitter, open-drain drive of PS2_CLK/PS2_DAT.
// Latency: INHIBIT_US clock inhibit, then one bit per device clock fall; done/err pulse after ACK/timeout.
// Backpressure: tx_ready high only in IDLE; tx_valid while busy is ignored.
// Ports: clk_cpu, rst (sync, active-high); tx_valid/tx_data/tx_ready request handshake;
//        tx_done/tx_err 1-cycle result pulses; rx_inhibit tells the receiver to ignore the lines;
//        ps2_clk_i/ps2_dat_i async pin levels; ps2_clk_oe/ps2_dat_oe pull the lines low when 1.
// Option: define PS2_TX_RETRY_EN to retry a failed frame once before pulsing tx_err.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_US = 15000,
    parameter int FILT_LEN   = 8
) (
    input  logic       clk_cpu,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_inhibit,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int INH_CYC = cycles_from_us(CLK_HZ, INHIBIT_US);
    localparam int TO_CYC  = cycles_from_us(CLK_HZ, TIMEOUT_US);
    localparam int CNT_MAX = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INH_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC - 1);

    ps2_tx_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;       // inhibit timer, then timeout timer
    logic [3:0]       idx, idx_nxt;       // next frame bit to drive
    logic [9:0]       frame, frame_nxt;   // {stop, parity, data[7:0]}
    logic             dat_oe, dat_oe_nxt;
    logic             done_c, err_c;

    logic clk_level, clk_fall;
    logic dat_level, dat_fall_unused;   // data-line edges are not needed here

`ifdef PS2_TX_RETRY_EN
    logic retried, retried_nxt;
`endif

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk   (clk_cpu),
        .rst   (rst),
        .line  (ps2_clk_i),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_dat_filt (
        .clk   (clk_cpu),
        .rst   (rst),
        .line  (ps2_dat_i),
        .level (dat_level),
        .fall  (dat_fall_unused)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        frame_nxt  = frame;
        dat_oe_nxt = dat_oe;
        done_c     = 1'b0;
        err_c      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retried_nxt = retried;
`endif
        case (state)
            ST_IDLE: begin
`ifdef PS2_TX_RETRY_EN
                retried_nxt = 1'b0;
`endif
                // Accepted even if the device is mid-transmit: inhibit aborts it.
                if (tx_valid) begin
                    frame_nxt = {1'b1, odd_parity(tx_data), tx_data};
                    cnt_nxt   = '0;
                    state_nxt = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt == INH_LAST) begin
                    dat_oe_nxt = 1'b1;   // start bit goes out as the clock is released
                    state_nxt  = ST_RTS;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_RTS: begin
                cnt_nxt   = '0;
                idx_nxt   = '0;
                state_nxt = ST_BITS;
            end
            ST_BITS: begin
                // A fall in the timeout cycle still counts as progress.
                if (clk_fall) begin
                    cnt_nxt    = '0;
                    dat_oe_nxt = ~frame[idx];
                    idx_nxt    = idx + 4'd1;
                    if (idx == 4'd9)
                        state_nxt = ST_ACK;
                end else if (cnt == TO_LAST) begin
                    state_nxt = ST_FAIL;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    cnt_nxt   = '0;
                    state_nxt = dat_level ? ST_FAIL : ST_WAIT_REL;
                end else if (cnt == TO_LAST) begin
                    state_nxt = ST_FAIL;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_WAIT_REL: begin
                if (clk_level && dat_level) begin
                    done_c    = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (clk_fall) begin
                    cnt_nxt = '0;
                end else if (cnt == TO_LAST) begin
                    state_nxt = ST_FAIL;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_FAIL: begin
`ifdef PS2_TX_RETRY_EN
                if (!retried) begin
                    retried_nxt = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = ST_INHIBIT;
                end else begin
                    err_c     = 1'b1;
                    state_nxt = ST_IDLE;
                end
`else
                err_c     = 1'b1;
                state_nxt = ST_IDLE;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Both lines are released for the whole FAIL cycle.
        if (state_nxt == ST_FAIL)
            dat_oe_nxt = 1'b0;
    end

    always_ff @(posedge clk_cpu) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            frame  <= '0;
            dat_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retried <= 1'b0;
`endif
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            frame  <= frame_nxt;
            dat_oe <= dat_oe_nxt;
`ifdef PS2_TX_RETRY_EN
            retried <= retried_nxt;
`endif
        end
    end

    // Handshake outputs are forced low while reset is held.
    assign tx_ready   = (state == ST_IDLE) && !rst;
    assign tx_done    = done_c && !rst;
    assign tx_err     = err_c && !rst;
    assign rx_inhibit = (state != ST_IDLE);
    assign ps2_clk_oe = (state == ST_INHIBIT);
    assign ps2_dat_oe = dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       glitch = 1'b0;
    logic       ps2_clk_i, ps2_dat_i;

    // Open-drain bus: any driver pulling low wins.
    assign ps2_clk_i = ~(ps2_clk_oe | dev_clk_low | glitch);
    assign ps2_dat_i = ~(ps2_dat_oe | dev_dat_low);

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int inh_phases = 0;
    logic clk_oe_d = 1'b0;

    // 1 MHz core clock: 1 cycle = 1 us, device clock period 80 cycles (12.5 kHz).
    ps2_host_tx #(
        .CLK_HZ(1_000_000), .INHIBIT_US(120), .TIMEOUT_US(15000), .FILT_LEN(8)
    ) dut (
        .clk_cpu(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .rx_inhibit(rx_inhibit),
        .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe)
    );

    initial forever #500 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (ps2_clk_oe && !clk_oe_d) inh_phases++;
        clk_oe_d = ps2_clk_oe;
    end

    // Device side of one host-to-device frame. bits[0]=start, [8:1]=data,
    // [9]=parity, [10]=stop as sampled in each clock-high phase.
    task automatic dev_frame(input bit do_ack, input bit glitchy, output logic [10:0] bits,
                             output int inh, output int drop, output bit ok);
        int n;
        ok = 1'b1; bits = '0; inh = 0; drop = 0; n = 0;
        while (!ps2_clk_oe && n < 2000) begin @(negedge clk); n++; end
        if (!ps2_clk_oe) begin ok = 1'b0; return; end
        while (ps2_clk_oe && inh < 2000) begin @(negedge clk); inh++; end
        repeat (20) @(negedge clk);
        bits[0] = ps2_dat_i;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            for (int c = 0; c < 40; c++) begin @(negedge clk); if (!rx_inhibit) drop++; end
            dev_clk_low = 1'b0;
            if (glitchy) begin
                repeat (5) @(negedge clk);
                glitch = 1'b1;
                repeat (3) @(negedge clk);
                glitch = 1'b0;
                repeat (12) @(negedge clk);
            end else begin
                repeat (20) @(negedge clk);
            end
            if (!rx_inhibit) drop++;
            bits[k] = ps2_dat_i;
            repeat (20) @(negedge clk);
        end
        if (do_ack) dev_dat_low = 1'b1;
        repeat (15) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (40) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (20) @(negedge clk);
        dev_dat_low = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_during_rst got %b want 0", tx_ready); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got %b want 1", tx_ready); end
        n_checks++; if ({tx_done, tx_err, rx_inhibit} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got %b want 000", {tx_done, tx_err, rx_inhibit}); end
        n_checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin n_fail++; $display("FAIL reset_oe got %b want 00", {ps2_clk_oe, ps2_dat_oe}); end
    endtask

    task automatic test_send_byte(input logic [7:0] d, input logic [10:0] exp_bits, input bit glitchy);
        logic [10:0] got;
        int inh, drop, n, d0, e0, p0;
        bit ok;
        d0 = done_cnt; e0 = err_cnt; p0 = inh_phases;
        @(negedge clk); tx_valid = 1'b1; tx_data = d;
        @(negedge clk); tx_valid = 1'b0;
        dev_frame(1'b1, glitchy, got, inh, drop, ok);
        n = 0;
        while (done_cnt == d0 && n < 300) begin @(negedge clk); n++; end
        @(negedge clk);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL send_%h_started got %b want 1", d, ok); end
        n_checks++; if (inh != 120) begin n_fail++; $display("FAIL send_%h_inhibit_cycles got %0d want 120", d, inh); end
        n_checks++; if (got !== exp_bits) begin n_fail++; $display("FAIL send_%h_frame got %h want %h", d, got, exp_bits); end
        n_checks++; if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL send_%h_done_pulses got %0d want 1", d, done_cnt - d0); end
        n_checks++; if (err_cnt != e0) begin n_fail++; $display("FAIL send_%h_err_pulses got %0d want 0", d, err_cnt - e0); end
        n_checks++; if (inh_phases != p0 + 1) begin n_fail++; $display("FAIL send_%h_inhibit_phases got %0d want 1", d, inh_phases - p0); end
        n_checks++; if (drop != 0) begin n_fail++; $display("FAIL send_%h_rx_inhibit_low got %0d want 0", d, drop); end
        n_checks++; if ({tx_ready, rx_inhibit, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
            n_fail++; $display("FAIL send_%h_idle_after got %b want 1000", d, {tx_ready, rx_inhibit, ps2_clk_oe, ps2_dat_oe}); end
    endtask

    task automatic test_nack();
        logic [10:0] got;
        int inh, drop, n, d0, e0, p0, exp_ph;
        bit ok;
        d0 = done_cnt; e0 = err_cnt; p0 = inh_phases;
`ifdef PS2_TX_RETRY_EN
        exp_ph = 2;
`else
        exp_ph = 1;
`endif
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hED;
        @(negedge clk); tx_valid = 1'b0;
        dev_frame(1'b0, 1'b0, got, inh, drop, ok);
`ifdef PS2_TX_RETRY_EN
        dev_frame(1'b0, 1'b0, got, inh, drop, ok);
`endif
        n = 0;
        while (err_cnt == e0 && n < 300) begin @(negedge clk); n++; end
        @(negedge clk);
        n_checks++; if (err_cnt != e0 + 1) begin n_fail++; $display("FAIL nack_err_pulses got %0d want 1", err_cnt - e0); end
        n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL nack_done_pulses got %0d want 0", done_cnt - d0); end
        n_checks++; if (inh_phases != p0 + exp_ph) begin n_fail++; $display("FAIL nack_inhibit_phases got %0d want %0d", inh_phases - p0, exp_ph); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL nack_ready_after got %b want 1", tx_ready); end
    endtask

    task automatic test_timeout();
        int n, lowc, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk); tx_valid = 1'b0;
        n = 0; lowc = 0;
        while (!tx_err && n < 40000) begin
            if (ps2_clk_oe) lowc = 0; else lowc++;
            @(negedge clk); n++;
        end
        n_checks++; if (tx_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_seen got %b want 1", tx_err); end
        n_checks++; if (lowc < 15000 || lowc > 15002) begin n_fail++; $display("FAIL timeout_cycles got %0d want 15000..15002", lowc); end
        n_checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin n_fail++; $display("FAIL timeout_oe got %b want 00", {ps2_clk_oe, ps2_dat_oe}); end
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_ready got %b want 1", tx_ready); end
        n_checks++; if (done_cnt != d0 || err_cnt != e0 + 1) begin
            n_fail++; $display("FAIL timeout_pulses got done %0d err %0d want done 0 err 1", done_cnt - d0, err_cnt - e0); end
    endtask

    task automatic test_reset_mid_frame();
        int n, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'h00;
        @(negedge clk); tx_valid = 1'b0;
        n = 0;
        while (!ps2_clk_oe && n < 2000) begin @(negedge clk); n++; end
        while (ps2_clk_oe && n < 4000) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            dev_clk_low = 1'b1; repeat (40) @(negedge clk);
            dev_clk_low = 1'b0; repeat (40) @(negedge clk);
        end
        n_checks++; if ({rx_inhibit, ps2_dat_oe} !== 2'b11) begin n_fail++; $display("FAIL midrst_busy_before got %b want 11", {rx_inhibit, ps2_dat_oe}); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin n_fail++; $display("FAIL midrst_oe got %b want 00", {ps2_clk_oe, ps2_dat_oe}); end
        n_checks++; if ({tx_ready, tx_done, tx_err, rx_inhibit} !== 4'b0000) begin
            n_fail++; $display("FAIL midrst_outputs got %b want 0000", {tx_ready, tx_done, tx_err, rx_inhibit}); end
        rst = 1'b0;
        repeat (300) @(negedge clk);
        n_checks++; if (done_cnt != d0 || err_cnt != e0) begin
            n_fail++; $display("FAIL midrst_no_pulses got done %0d err %0d want 0 0", done_cnt - d0, err_cnt - e0); end
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", tx_ready); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] got;
        int inh, drop, n, p0;
        bit ok;
        p0 = inh_phases;
        @(negedge clk); tx_valid = 1'b1; tx_data = 8'h01;
        dev_frame(1'b1, 1'b0, got, inh, drop, ok);
        n_checks++; if (got !== 11'h402) begin n_fail++; $display("FAIL b2b_frame1 got %h want 402", got); end
        n_checks++; if (inh_phases != p0 + 1) begin n_fail++; $display("FAIL b2b_held_valid_phases got %0d want 1", inh_phases - p0); end
        n = 0;
        while (!tx_done && n < 300) begin @(negedge clk); n++; end
        n_checks++; if ({tx_done, tx_ready} !== 2'b10) begin n_fail++; $display("FAIL b2b_done_cycle got %b want 10", {tx_done, tx_ready}); end
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_next got %b want 1", tx_ready); end
        @(negedge clk);
        tx_valid = 1'b0;
        n_checks++; if (ps2_clk_oe !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept got %b want 1", ps2_clk_oe); end
        dev_frame(1'b1, 1'b0, got, inh, drop, ok);
        n = 0;
        while (!tx_ready && n < 300) begin @(negedge clk); n++; end
        n_checks++; if (got !== 11'h402 || inh != 120) begin n_fail++; $display("FAIL b2b_frame2 got %h/%0d want 402/120", got, inh); end
        n_checks++; if (inh_phases != p0 + 2) begin n_fail++; $display("FAIL b2b_total_phases got %0d want 2", inh_phases - p0); end
    endtask

    initial begin
        test_reset();
        test_send_byte(8'hED, 11'h7DA, 1'b0);
        test_send_byte(8'h00, 11'h600, 1'b0);
        test_send_byte(8'hFF, 11'h7FE, 1'b0);
        test_nack();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        test_send_byte(8'h5A, 11'h6B4, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
